instr_encoder: RTL

- Inverse of the pipeline's instruction decoder: packs field-level requests (format class, rd, rs1, rs2, func3, func7 bit, full 32-bit immediate) into RV32I instruction words.
- Writes the packed words sequentially into instruction memory through a simple write port.
- Used by the test/boot loader path to build programs in IMEM before the core is released from reset.
- Requests whose immediate cannot be encoded are rejected and counted, not written.

---
 rtl/instr_encoder_if.sv | 37 +++
 rtl/instr_encoder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// Request and IMEM write-port bundle for the instruction encoder.
// The loader drives the master side and the encoder is the slave.
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_fmt;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_func3;
    logic              in_func7;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              err;
    logic [7:0]        err_cnt;
    logic              done;
    logic              overflow;

    modport master (
        output start, base_addr, in_valid, in_fmt, in_rd, in_rs1, in_rs2,
               in_func3, in_func7, in_imm, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata, err, err_cnt, done, overflow
    );

    modport slave (
        input  start, base_addr, in_valid, in_fmt, in_rd, in_rs1, in_rs2,
               in_func3, in_func7, in_imm, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata, err, err_cnt, done, overflow
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs field-level requests into RV32I words and writes them sequentially
// into IMEM; requests with unencodable immediates are rejected and counted.
module instr_encoder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input logic           clk,
    input logic           rst,
    instr_encoder_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [3:0] FMT_R     = 4'd0;
    localparam logic [3:0] FMT_I     = 4'd1;
    localparam logic [3:0] FMT_L     = 4'd2;
    localparam logic [3:0] FMT_S     = 4'd3;
    localparam logic [3:0] FMT_B     = 4'd4;
    localparam logic [3:0] FMT_JAL   = 4'd5;
    localparam logic [3:0] FMT_JALR  = 4'd6;
    localparam logic [3:0] FMT_LUI   = 4'd7;
    localparam logic [3:0] FMT_AUIPC = 4'd8;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  count;
    logic [31:0]       word;
    logic              bad;
    logic              accept;

    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        sext12, sext13, sext21, is_shift;

    assign imm      = bus.in_imm;
    assign rd       = bus.in_rd;
    assign rs1      = bus.in_rs1;
    assign rs2      = bus.in_rs2;
    assign f3       = bus.in_func3;
    assign sext12   = (imm[31:11] == {21{imm[11]}});
    assign sext13   = (imm[31:12] == {20{imm[12]}});
    assign sext21   = (imm[31:20] == {12{imm[20]}});
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    assign bus.in_ready = (state == RUN) && (count < CNT_W'(DEPTH));
    assign accept       = bus.in_valid && bus.in_ready;

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        word = '0;
        bad  = 1'b0;
        case (bus.in_fmt)
            FMT_R:     word = {1'b0, bus.in_func7, 5'b0, rs2, rs1, f3, rd, OP_R};
            FMT_I: begin
                if (is_shift) begin
                    bad  = |imm[31:5];
                    word = {1'b0, bus.in_func7, 5'b0, imm[4:0], rs1, f3, rd, OP_I};
                end else begin
                    bad  = !sext12;
                    word = {imm[11:0], rs1, f3, rd, OP_I};
                end
            end
            FMT_L: begin
                bad  = !sext12;
                word = {imm[11:0], rs1, f3, rd, OP_L};
            end
            FMT_JALR: begin
                bad  = !sext12;
                word = {imm[11:0], rs1, f3, rd, OP_JALR};
            end
            FMT_S: begin
                bad  = !sext12;
                word = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_S};
            end
            FMT_B: begin
                bad  = !sext13 || imm[0];
                word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_B};
            end
            FMT_JAL: begin
                bad  = !sext21 || imm[0];
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            end
            FMT_LUI: begin
                bad  = |imm[11:0];
                word = {imm[31:12], rd, OP_LUI};
            end
            FMT_AUIPC: begin
                bad  = |imm[11:0];
                word = {imm[31:12], rd, OP_AUIPC};
            end
            default:   bad = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is asynchronous so mem_we drops at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            base          <= '0;
            count         <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.err       <= 1'b0;
            bus.err_cnt   <= '0;
            bus.done      <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            bus.err    <= 1'b0;
            // start wins over a same-cycle request so a restart is always clean
            if (bus.start) begin
                state        <= RUN;
                base         <= bus.base_addr;
                count        <= '0;
                bus.done     <= 1'b0;
                bus.overflow <= 1'b0;
            end else if (accept) begin
                if (bad) begin
                    bus.err <= 1'b1;
                    if (bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
                    if (bus.in_last) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end
                end else begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= base + ADDR_W'(count);
                    bus.mem_wdata <= word;
                    count         <= count + CNT_W'(1);
                    if (bus.in_last) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else if (count == CNT_W'(DEPTH - 1)) begin
                        state        <= DONE;
                        bus.done     <= 1'b1;
                        bus.overflow <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
